// File: rtl/byte_unstriping.sv
// Two-lane receive unstriper: per-lane FIFOs absorb skew and re-serialise
// lane_0/lane_1 words round-robin onto one stream at the clk_2f rate.

module byte_unstriping_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_nxt,
  output logic          o_empty,
  output logic          o_drop
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop & ~o_empty;
  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign w_wr    = i_push & (~w_full | w_rd);
  assign o_drop  = i_push & w_full & ~w_rd;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_comb begin
    o_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   o_count_nxt = r_count + CW'(1);
      2'b01:   o_count_nxt = r_count - CW'(1);
      default: o_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= o_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

module byte_unstriping #(
  parameter int DEPTH      = 4,
  parameter int SKEW_LIMIT = 3
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] lane_0,
  input  logic [31:0] lane_1,
  input  logic        valid_in0,
  input  logic        valid_in1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        overflow,
  output logic        skew_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] SKEW_LIM = CW'(SKEW_LIMIT);

  logic          r_phase;
  logic          r_sel;
  logic [31:0]   r_data_out;
  logic          r_valid_out;
  logic          r_overflow;
  logic          r_skew_err;

  logic          w_push0, w_push1;
  logic          w_pop0, w_pop1;
  logic [31:0]   w_head0, w_head1;
  logic [CW-1:0] w_cnt0, w_cnt1;
  logic [CW-1:0] w_cnt0_nxt, w_cnt1_nxt;
  logic          w_empty0, w_empty1;
  logic          w_drop0, w_drop1;
  logic [CW-1:0] w_diff;
  logic          w_pop_any;

  // Lanes are sampled once per clk_f word, on the phase==1 half.
  assign w_push0   = r_phase & valid_in0;
  assign w_push1   = r_phase & valid_in1;
  assign w_pop0    = ~r_sel & ~w_empty0;
  assign w_pop1    = r_sel & ~w_empty1;
  assign w_pop_any = w_pop0 | w_pop1;

  byte_unstriping_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo0 (
    .clk         (clk_2f),
    .reset       (reset),
    .i_push      (w_push0),
    .i_pop       (w_pop0),
    .i_wdata     (lane_0),
    .o_rdata     (w_head0),
    .o_count     (w_cnt0),
    .o_count_nxt (w_cnt0_nxt),
    .o_empty     (w_empty0),
    .o_drop      (w_drop0)
  );

  byte_unstriping_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo1 (
    .clk         (clk_2f),
    .reset       (reset),
    .i_push      (w_push1),
    .i_pop       (w_pop1),
    .i_wdata     (lane_1),
    .o_rdata     (w_head1),
    .o_count     (w_cnt1),
    .o_count_nxt (w_cnt1_nxt),
    .o_empty     (w_empty1),
    .o_drop      (w_drop1)
  );

  always_comb begin
    w_diff = '0;
    if (w_cnt0_nxt > w_cnt1_nxt) w_diff = w_cnt0_nxt - w_cnt1_nxt;
    else                         w_diff = w_cnt1_nxt - w_cnt0_nxt;
  end

  // sel never skips an empty lane, which keeps the lane_0/lane_1 order intact.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_phase     <= 1'b0;
      r_sel       <= 1'b0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_skew_err  <= 1'b0;
    end else begin
      r_phase     <= ~r_phase;
      r_valid_out <= w_pop_any;
      if (w_pop_any) begin
        r_data_out <= r_sel ? w_head1 : w_head0;
        r_sel      <= ~r_sel;
      end
      if (w_drop0 | w_drop1) r_overflow <= 1'b1;
      if (w_diff > SKEW_LIM) r_skew_err <= 1'b1;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;
  assign skew_err  = r_skew_err;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: hand-computed output sequences,
// flag behaviour and cycle-exact first-output latency.

module tb_byte_unstriping;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] lane_0, lane_1;
  logic        valid_in0, valid_in1;
  logic [31:0] data_out;
  logic        valid_out, overflow, skew_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rel_cyc;
  int bad;

  logic [31:0] cap_q[$];
  int          cap_cyc[$];
  logic [31:0] exp_q[$];

  always #5 clk_2f = ~clk_2f;

  byte_unstriping #(.DEPTH(4), .SKEW_LIMIT(3)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .lane_0    (lane_0),
    .lane_1    (lane_1),
    .valid_in0 (valid_in0),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  always @(posedge clk_2f) cyc++;

  always @(negedge clk_2f) begin
    if (valid_out === 1'b1) begin
      cap_q.push_back(data_out);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Holds one clk_f word for two edges; the second edge is the phase==1 sample.
  task automatic send(input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1);
    valid_in0 = v0; lane_0 = d0;
    valid_in1 = v1; lane_1 = d1;
    @(posedge clk_2f);
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic idle_words(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    lane_0 = '0; lane_1 = '0;
    repeat (2) @(negedge clk_2f);
    reset = 1'b0;
    rel_cyc = cyc;
    cap_q.delete();
    cap_cyc.delete();
  endtask

  task automatic check_seq(input string tag);
    check_eq($sformatf("%s_len", tag), 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), cap_q[i], exp_q[i]);
  endtask

  initial begin
    // 1: reset state and quiet idle
    reset = 1'b1;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    lane_0 = '0; lane_1 = '0;
    repeat (4) @(negedge clk_2f);
    check_eq("t1_rst_data", data_out, 32'h0);
    check_eq("t1_rst_valid", 32'(valid_out), 32'h0);
    check_eq("t1_rst_ovf", 32'(overflow), 32'h0);
    check_eq("t1_rst_skew", 32'(skew_err), 32'h0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_2f);
      if ({data_out, valid_out, overflow, skew_err} !== '0) bad++;
    end
    check_eq("t1_idle_nonzero_cycles", 32'(bad), 32'h0);

    // 2: aligned stream, first output one edge after the first push
    do_reset();
    send(1'b1, 32'hA0, 1'b1, 32'hA1);
    send(1'b1, 32'hA2, 1'b1, 32'hA3);
    send(1'b1, 32'hA4, 1'b1, 32'hA5);
    idle_words(3);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    check_seq("t2_seq");
    if (cap_cyc.size() == 6) begin
      check_eq("t2_first_cycle", 32'(cap_cyc[0] - rel_cyc), 32'd3);
      check_eq("t2_span", 32'(cap_cyc[5] - cap_cyc[0]), 32'd5);
    end

    // 3: lane_1 two words late
    do_reset();
    send(1'b1, 32'h10, 1'b0, 32'h0);
    send(1'b1, 32'h12, 1'b0, 32'h0);
    check_eq("t3_wait_valid_low", 32'(valid_out), 32'h0);
    send(1'b1, 32'h14, 1'b1, 32'h11);
    send(1'b0, 32'h0, 1'b1, 32'h13);
    send(1'b0, 32'h0, 1'b1, 32'h15);
    idle_words(3);
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
    check_seq("t3_seq");
    check_eq("t3_skew", 32'(skew_err), 32'h0);
    check_eq("t3_ovf", 32'(overflow), 32'h0);

    // 4: overflow on lane 0, then drain through lane 1 to show 0x2..0x5 kept
    do_reset();
    for (int w = 1; w <= 6; w++) begin
      send(1'b1, 32'(w), 1'b0, 32'h0);
      if (w == 4) check_eq("t4_skew_at4", 32'(skew_err), 32'h0);
      if (w == 5) begin
        check_eq("t4_skew_at5", 32'(skew_err), 32'h1);
        check_eq("t4_ovf_at5", 32'(overflow), 32'h0);
      end
      if (w == 6) check_eq("t4_ovf_at6", 32'(overflow), 32'h1);
    end
    for (int w = 1; w <= 5; w++) send(1'b0, 32'h0, 1'b1, 32'h50 + 32'(w));
    idle_words(3);
    exp_q = '{32'h1, 32'h51, 32'h2, 32'h52, 32'h3, 32'h53, 32'h4, 32'h54, 32'h5, 32'h55};
    check_seq("t4_seq");
    check_eq("t4_ovf_sticky", 32'(overflow), 32'h1);
    check_eq("t4_skew_sticky", 32'(skew_err), 32'h1);

    // 5: reset mid-stream with both FIFOs occupied and both flags set
    do_reset();
    for (int w = 1; w <= 5; w++) send(1'b0, 32'h0, 1'b1, 32'hC0 + 32'(w));
    send(1'b1, 32'hC0, 1'b0, 32'h0);
    check_eq("t5_pre_ovf", 32'(overflow), 32'h1);
    check_eq("t5_pre_skew", 32'(skew_err), 32'h1);
    reset = 1'b1;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    @(negedge clk_2f);
    check_eq("t5_rst_valid", 32'(valid_out), 32'h0);
    check_eq("t5_rst_data", data_out, 32'h0);
    check_eq("t5_rst_ovf", 32'(overflow), 32'h0);
    check_eq("t5_rst_skew", 32'(skew_err), 32'h0);
    @(negedge clk_2f);
    reset = 1'b0;
    cap_q.delete();
    cap_cyc.delete();
    send(1'b1, 32'hB0, 1'b1, 32'hB1);
    idle_words(4);
    exp_q = '{32'hB0, 32'hB1};
    check_seq("t5_seq");

    // 6: lane_1 arrives first but lane_0 must still lead
    do_reset();
    send(1'b0, 32'h0, 1'b1, 32'h21);
    check_eq("t6_hold_valid", 32'(valid_out), 32'h0);
    send(1'b1, 32'h20, 1'b0, 32'h0);
    idle_words(3);
    exp_q = '{32'h20, 32'h21};
    check_seq("t6_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
